// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: classifies the immediate format of each accepted
// instruction, extends it to XLEN and queues it with its sideband tag in a 2-entry FIFO.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam bit IS64 = (XLEN == 64);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  // Decode: every candidate immediate is built as a signed 32-bit value first
  logic        [6:0]  opcode;
  logic        [2:0]  funct3;
  logic signed [31:0] imm_i_w;
  logic signed [31:0] imm_s_w;
  logic signed [31:0] imm_b_w;
  logic signed [31:0] imm_u_w;
  logic signed [31:0] imm_j_w;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign imm_i_w = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_w = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_w = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_w = {instr[31:12], 12'b0};
  assign imm_j_w = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  entry_t dec;

  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    dec.tag = in_tag;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec.imm = sext32(imm_u_w);
        dec.fmt = FMT_U;
      end
      OP_JAL: begin
        dec.imm = sext32(imm_j_w);
        dec.fmt = FMT_J;
      end
      OP_JALR, OP_LOAD: begin
        dec.imm = sext32(imm_i_w);
        dec.fmt = FMT_I;
      end
      OP_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.fmt = FMT_SH;
          // RV32 has only 5 shamt bits; a set bit 25 is a reserved encoding
          if (IS64) begin
            dec.imm = zext6(instr[25:20]);
          end else begin
            dec.imm = zext6({1'b0, instr[24:20]});
            dec.ill = instr[25];
          end
        end else begin
          dec.imm = sext32(imm_i_w);
          dec.fmt = FMT_I;
        end
      end
      OP_STORE: begin
        dec.imm = sext32(imm_s_w);
        dec.fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec.imm = sext32(imm_b_w);
        dec.fmt = FMT_B;
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec.imm = zext6({1'b0, instr[19:15]});
          dec.fmt = FMT_Z;
        end else begin
          dec.imm = sext32(imm_i_w);
          dec.fmt = FMT_I;
        end
      end
      OP_OP, OP_FENCE: begin
        dec.ill = 1'b0;
      end
      default: begin
        dec.ill = 1'b1;
      end
    endcase
  end

  // Buffer: entry 0 is always the head and directly drives the outputs
  logic [1:0] cnt_q, cnt_d;
  entry_t     e0_q, e0_d;
  entry_t     e1_q, e1_d;
  logic       push;
  logic       pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      // push implies count<2 and pop implies count>0, so count is 1 here
      e0_d = dec;
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        e0_d = dec;
      end else begin
        e1_d = dec;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      // popping the last entry leaves entry 0 untouched so outputs hold
      if (cnt_q == 2'd2) begin
        e0_d = e1_q;
      end
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign imm     = e0_q.imm;
  assign fmt     = e0_q.fmt;
  assign illegal = e0_q.ill;
  assign out_tag = e0_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream and
// are checked every cycle against a queue model plus hand-computed literal vectors.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] in_tag = 32'h0;

  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .imm(imm32), .fmt(fmt32), .illegal(ill32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .imm(imm64), .fmt(fmt64), .illegal(ill64), .out_tag(tag64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decode in plain integer arithmetic
  function automatic longint simm12(input logic [11:0] f);
    longint r;
    r = longint'(f);
    if (r >= 2048) r = r - 4096;
    return r;
  endfunction

  function automatic void mdec(input logic [31:0] ins, input bit x64,
                               output logic [63:0] mimm, output logic [2:0] mfmt,
                               output bit mill);
    longint v;
    int opc, f3;
    opc  = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    v    = 0;
    mfmt = 3'd0;
    mill = 1'b0;
    case (opc)
      'h37, 'h17: begin v = longint'($signed(ins & 32'hFFFFF000)); mfmt = 3'd4; end
      'h6F: begin
        v = (ins[31] ? -1048576 : 0) + longint'(ins[19:12]) * 4096
            + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        mfmt = 3'd5;
      end
      'h67, 'h03: begin v = simm12(ins[31:20]); mfmt = 3'd1; end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          mfmt = 3'd7;
          if (x64) v = longint'(ins[25:20]);
          else begin v = longint'(ins[24:20]); mill = ins[25]; end
        end else begin
          v = simm12(ins[31:20]); mfmt = 3'd1;
        end
      end
      'h23: begin v = simm12({ins[31:25], ins[11:7]}); mfmt = 3'd2; end
      'h63: begin
        v = (ins[31] ? -4096 : 0) + longint'(ins[7]) * 2048
            + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        mfmt = 3'd3;
      end
      'h73: begin
        if (f3 >= 4) begin v = longint'(ins[19:15]); mfmt = 3'd6; end
        else begin v = simm12(ins[31:20]); mfmt = 3'd1; end
      end
      'h33, 'h0F: v = 0;
      default: mill = 1'b1;
    endcase
    mimm = x64 ? 64'(v) : {32'h0, 64'(v) & 64'hFFFF_FFFF};
  endfunction

  // Model: FIFO of accepted instructions plus the entry the outputs currently show
  typedef struct {
    logic [31:0] ins;
    logic [31:0] tag;
  } ent_t;

  ent_t mq[$];
  ent_t shown;
  bit   shown_zero = 1'b1;
  bit   m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      shown_zero = 1'b1;
    end else begin
      m_push = in_valid && (mq.size() < 2) && !flush;
      m_pop  = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back('{instr, in_tag});
      end
      if (mq.size() > 0) begin
        shown      = mq[0];
        shown_zero = 1'b0;
      end
    end
  end

  logic [63:0] c_e32, c_e64;
  logic [2:0]  c_f32, c_f64;
  bit          c_i32, c_i64;
  logic [31:0] c_tag;

  always @(negedge clk) begin
    if (shown_zero) begin
      c_e32 = 64'h0; c_e64 = 64'h0; c_f32 = 3'd0; c_f64 = 3'd0;
      c_i32 = 1'b0; c_i64 = 1'b0; c_tag = 32'h0;
    end else begin
      mdec(shown.ins, 1'b0, c_e32, c_f32, c_i32);
      mdec(shown.ins, 1'b1, c_e64, c_f64, c_i64);
      c_tag = shown.tag;
    end
    chk("m_in_ready32", 64'(rdy32), 64'(mq.size() != 2));
    chk("m_in_ready64", 64'(rdy64), 64'(mq.size() != 2));
    chk("m_out_valid32", 64'(ov32), 64'(mq.size() != 0));
    chk("m_out_valid64", 64'(ov64), 64'(mq.size() != 0));
    chk("m_imm32", {32'h0, imm32}, c_e32);
    chk("m_imm64", imm64, c_e64);
    chk("m_fmt32", 64'(fmt32), 64'(c_f32));
    chk("m_fmt64", 64'(fmt64), 64'(c_f64));
    chk("m_ill32", 64'(ill32), 64'(c_i32));
    chk("m_ill64", 64'(ill64), 64'(c_i64));
    chk("m_tag32", 64'(tag32), 64'(c_tag));
    chk("m_tag64", 64'(tag64), 64'(c_tag));
  end

  // Offer one instruction and wait (bounded) until it has been accepted
  task automatic send(input logic [31:0] ins, input logic [31:0] tag);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    instr    = ins;
    in_tag   = tag;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rdy32) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout tag=%0h accepted=0 required=1", tag);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] ins, input logic [31:0] tag,
                     input logic [31:0] e32, input logic [2:0] f32, input bit i32,
                     input logic [63:0] e64, input logic [2:0] f64, input bit i64);
    send(ins, tag);
    chk({name, "_valid"}, 64'(ov32), 64'd1);
    chk({name, "_imm32"}, 64'(imm32), 64'(e32));
    chk({name, "_fmt32"}, 64'(fmt32), 64'(f32));
    chk({name, "_ill32"}, 64'(ill32), 64'(i32));
    chk({name, "_imm64"}, imm64, e64);
    chk({name, "_fmt64"}, 64'(fmt64), 64'(f64));
    chk({name, "_ill64"}, 64'(ill64), 64'(i64));
    chk({name, "_tag"}, 64'(tag32), 64'(tag));
  endtask

  logic [31:0] vec [16] = '{
    32'hFFF00093, 32'hFE112E23, 32'h800002B7, 32'h02109093,
    32'h3002D073, 32'h0000007F, 32'h12345097, 32'hFE1FF0EF,
    32'hFE000EE3, 32'h00008067, 32'h80002083, 32'h4030D093,
    32'h002081B3, 32'h0000000F, 32'h34011073, 32'h03F09093
  };

  initial begin
    @(negedge clk);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_imm", 64'(imm32), 64'd0);
    chk("rst_tag", 64'(tag64), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(rdy32), 64'd1);

    // Hand-computed decode vectors
    out_ready = 1'b1;
    lit("addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    lit("sw", 32'hFE112E23, 32'h104, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    lit("lui", 32'h800002B7, 32'h108, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    lit("slli", 32'h02109093, 32'h10C, 32'h00000001, 3'd7, 1'b1, 64'd33, 3'd7, 1'b0);
    lit("csrrwi", 32'h3002D073, 32'h110, 32'h00000005, 3'd6, 1'b0, 64'd5, 3'd6, 1'b0);
    lit("badop", 32'h0000007F, 32'h114, 32'h00000000, 3'd0, 1'b1, 64'd0, 3'd0, 1'b1);
    lit("beq", 32'hFE000EE3, 32'h118, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    @(negedge clk);
    chk("drained_valid", 64'(ov32), 64'd0);
    chk("hold_tag", 64'(tag32), 64'h118);

    // Back-pressure: A,B fill the buffer, C waits, then all drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1; instr = 32'h00100093; in_tag = 32'hA;
    @(negedge clk);
    instr = 32'h00200093; in_tag = 32'hB;
    @(negedge clk);
    instr = 32'h00300093; in_tag = 32'hC;
    chk("full_in_ready", 64'(rdy32), 64'd0);
    @(negedge clk);
    chk("full_in_ready2", 64'(rdy64), 64'd0);
    chk("full_head_tag", 64'(tag32), 64'hA);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_b", 64'(tag32), 64'hB);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_c", 64'(tag32), 64'hC);
    chk("drain_c_imm", 64'(imm32), 64'd3);
    @(negedge clk);
    chk("drain_empty", 64'(ov32), 64'd0);

    // Flush with a full buffer and a competing push
    out_ready = 1'b0;
    send(32'h00500093, 32'hD);
    send(32'h00600093, 32'hE);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h00700093; in_tag = 32'hF0F; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(ov32), 64'd0);
    chk("flush_in_ready", 64'(rdy32), 64'd1);
    chk("flush_hold_tag", 64'(tag32), 64'hD);
    repeat (3) @(negedge clk);
    chk("flush_stays_empty", 64'(ov64), 64'd0);
    send(32'h00800093, 32'h60);
    chk("after_flush_tag", 64'(tag32), 64'h60);

    // Directed stream with a fixed back-pressure pattern
    for (int k = 0; k < 16; k++) begin
      out_ready = (k % 3) != 0;
      send(vec[k], 32'h200 + 32'(k));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && ov32; i++) @(negedge clk);
    chk("stream_drained", 64'(ov32), 64'd0);

    // Asynchronous reset mid-stream with two entries queued
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h300);
    send(32'hFE112E23, 32'h304);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid32", 64'(ov32), 64'd0);
    chk("arst_valid64", 64'(ov64), 64'd0);
    chk("arst_imm32", 64'(imm32), 64'd0);
    chk("arst_imm64", imm64, 64'd0);
    chk("arst_fmt", 64'(fmt32), 64'd0);
    chk("arst_tag", 64'(tag32), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_in_ready", 64'(rdy32), 64'd1);
    out_ready = 1'b1;
    lit("restart", 32'hFFF00093, 32'h400, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
